// File: rtl/dmem_byte_bridge_if.sv
// Word-wide data-memory request/response channel between the core's
// load/store path (master) and the byte bridge (slave).
interface dmem_byte_bridge_if;
  logic        i_req_valid;
  logic        o_req_ready;
  logic [31:0] i_addr;
  logic        i_write_enable;
  logic [31:0] i_write_data;
  logic [31:0] i_mask;
  logic        o_rsp_valid;
  logic        i_rsp_ready;
  logic [31:0] o_read_data;

  modport slave (
    input  i_req_valid, i_addr, i_write_enable, i_write_data, i_mask, i_rsp_ready,
    output o_req_ready, o_rsp_valid, o_read_data
  );

  modport master (
    output i_req_valid, i_addr, i_write_enable, i_write_data, i_mask, i_rsp_ready,
    input  o_req_ready, o_rsp_valid, o_read_data
  );
endinterface

// File: rtl/dmem_byte_bridge.sv
// Serialises a byte-masked 32-bit load/store into one SRAM byte access per
// enabled lane, then returns the lane-positioned read word (0 for stores).
module dmem_byte_bridge #(
  parameter int ADDR_W = 11
) (
  input  logic              i_clk,
  input  logic              i_rst,
  dmem_byte_bridge_if.slave bus,
  output logic              o_sram_en,
  output logic              o_sram_we,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic [7:0]        o_sram_wdata,
  input  logic [7:0]        i_sram_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, DRAIN, RESP} state_t;

  state_t            state_q;
  logic [ADDR_W-3:0] word_q;     // latched word address
  logic              we_q;       // latched store flag
  logic [31:0]       wdata_q;    // latched store data
  logic [3:0]        pend_q;     // enabled lanes not yet issued
  logic [1:0]        lane_q;     // lane issued in the current ACCESS cycle
  logic              rd_pend_q;  // a read was issued last cycle
  logic [1:0]        rd_lane_q;  // lane that read belongs to
  logic [31:0]       asm_q;      // read-assembly word
  logic              sram_en_q;
  logic              sram_we_q;
  logic [ADDR_W-1:0] sram_addr_q;
  logic [7:0]        sram_wdata_q;

  // Lowest enabled lane wins, giving ascending issue order.
  function automatic logic [1:0] first_lane(input logic [3:0] m);
    if (m[0])      return 2'd0;
    else if (m[1]) return 2'd1;
    else if (m[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  logic              accept_d;
  logic [3:0]        req_lanes_d;
  logic [3:0]        src_lanes_d;
  logic [1:0]        nxt_lane_d;
  logic [3:0]        rem_lanes_d;
  logic [ADDR_W-3:0] word_d;
  logic [31:0]       wsrc_d;
  logic              we_d;
  logic              issue_d;

  // In IDLE the next access comes straight from the request; afterwards it
  // comes from the latched copy, so the request bus is only sampled once.
  always_comb begin
    accept_d    = (state_q == IDLE) && bus.i_req_valid;
    req_lanes_d = {bus.i_mask[24], bus.i_mask[16], bus.i_mask[8], bus.i_mask[0]};
    src_lanes_d = (state_q == IDLE) ? req_lanes_d : pend_q;
    nxt_lane_d  = first_lane(src_lanes_d);
    rem_lanes_d = src_lanes_d & ~(4'b0001 << nxt_lane_d);
    word_d      = (state_q == IDLE) ? bus.i_addr[ADDR_W-1:2] : word_q;
    wsrc_d      = (state_q == IDLE) ? bus.i_write_data : wdata_q;
    we_d        = (state_q == IDLE) ? bus.i_write_enable : we_q;
    issue_d     = (accept_d && (req_lanes_d != 4'b0000)) ||
                  ((state_q == ACCESS) && (pend_q != 4'b0000));
  end

  // Bridge FSM with registered SRAM strobes and read-byte reassembly.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= IDLE;
      word_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      pend_q       <= '0;
      lane_q       <= '0;
      rd_pend_q    <= 1'b0;
      rd_lane_q    <= '0;
      asm_q        <= '0;
      sram_en_q    <= 1'b0;
      sram_we_q    <= 1'b0;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
    end else begin
      // SRAM read data lags its access by one cycle.
      if (rd_pend_q) asm_q[8*rd_lane_q +: 8] <= i_sram_rdata;
      rd_pend_q <= sram_en_q & ~sram_we_q;
      rd_lane_q <= lane_q;

      sram_en_q    <= issue_d;
      sram_we_q    <= issue_d & we_d;
      sram_addr_q  <= issue_d ? {word_d, nxt_lane_d} : '0;
      sram_wdata_q <= issue_d ? wsrc_d[8*nxt_lane_d +: 8] : '0;
      if (issue_d) begin
        lane_q <= nxt_lane_d;
        pend_q <= rem_lanes_d;
      end

      case (state_q)
        IDLE: if (accept_d) begin
          word_q  <= word_d;
          we_q    <= we_d;
          wdata_q <= wsrc_d;
          asm_q   <= '0;
          state_q <= (req_lanes_d == 4'b0000) ? RESP : ACCESS;
        end
        ACCESS: if (pend_q == 4'b0000) state_q <= we_q ? RESP : DRAIN;
        DRAIN:  state_q <= RESP;
        RESP:   if (bus.i_rsp_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.o_req_ready = (state_q == IDLE);
  assign bus.o_rsp_valid = (state_q == RESP);
  assign bus.o_read_data = ((state_q == RESP) && !we_q) ? asm_q : 32'h0;

  assign o_sram_en    = sram_en_q;
  assign o_sram_we    = sram_we_q;
  assign o_sram_addr  = sram_addr_q;
  assign o_sram_wdata = sram_wdata_q;

  // Address bits outside the SRAM word and non-lane mask bits are ignored.
  logic unused_bits;
  assign unused_bits = ^{bus.i_addr[31:ADDR_W], bus.i_addr[1:0],
                         bus.i_mask[31:25], bus.i_mask[23:17],
                         bus.i_mask[15:9], bus.i_mask[7:1]};

endmodule

// File: tb/tb_dmem_byte_bridge.sv
// Directed bench for dmem_byte_bridge with a behavioural byte SRAM.
module tb_dmem_byte_bridge;
  localparam int ADDR_W = 11;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              sram_en, sram_we;
  logic [ADDR_W-1:0] sram_addr;
  logic [7:0]        sram_wdata;
  logic [7:0]        sram_rdata = 8'h00;

  dmem_byte_bridge_if bus();

  dmem_byte_bridge #(.ADDR_W(ADDR_W)) dut (
    .i_clk(clk), .i_rst(rst), .bus(bus),
    .o_sram_en(sram_en), .o_sram_we(sram_we), .o_sram_addr(sram_addr),
    .o_sram_wdata(sram_wdata), .i_sram_rdata(sram_rdata)
  );

  always #5 clk = ~clk;

  // Byte SRAM model with a preload port and an access log.
  logic [7:0]        mem [0:(1<<ADDR_W)-1];
  logic              pl_en = 1'b0;
  logic [ADDR_W-1:0] pl_addr = '0;
  logic [7:0]        pl_data = '0;
  logic              log_we   [0:255];
  logic [ADDR_W-1:0] log_addr [0:255];
  logic [7:0]        log_d    [0:255];
  int                log_n = 0;

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (sram_en) begin
      log_we[log_n]   <= sram_we;
      log_addr[log_n] <= sram_addr;
      log_d[log_n]    <= sram_we ? sram_wdata : mem[sram_addr];
      log_n           <= log_n + 1;
      if (sram_we) mem[sram_addr] <= sram_wdata;
      else         sram_rdata     <= mem[sram_addr];
    end
  end

  typedef struct {
    logic        we;
    logic [31:0] addr, wdata, mask, rd;
    int          lat, n;
    logic [3:0][10:0] ea;
    logic [3:0][7:0]  ed;
  } vec_t;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic poke(input int a, input logic [7:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a[ADDR_W-1:0]; pl_data = d;
    @(posedge clk); #1 pl_en = 1'b0;
  endtask

  function automatic vec_t mkv(input logic we, input logic [31:0] addr, wdata, mask, rd,
                               input int lat, n, input logic [43:0] ea, input logic [31:0] ed);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.mask = mask; v.rd = rd;
    v.lat = lat; v.n = n; v.ea = ea; v.ed = ed;
    return v;
  endfunction

  task automatic do_req(input vec_t v, input string nm);
    int start, lat;
    bit got;
    @(negedge clk);
    chk({nm, ".req_ready"}, {31'd0, bus.o_req_ready}, 32'd1);
    start = log_n;
    bus.i_req_valid = 1'b1; bus.i_addr = v.addr; bus.i_write_enable = v.we;
    bus.i_write_data = v.wdata; bus.i_mask = v.mask; bus.i_rsp_ready = 1'b1;
    @(posedge clk);
    got = 1'b0; lat = 0;
    for (int k = 1; k <= 20 && !got; k++) begin
      @(negedge clk);
      if (k == 1) begin
        // Inputs must be ignored after acceptance.
        bus.i_req_valid = 1'b0; bus.i_addr = 32'hffff_ffff;
        bus.i_write_data = 32'h5a5a_5a5a; bus.i_mask = 32'hffff_ffff;
        bus.i_write_enable = ~v.we;
      end
      lat = k; got = bus.o_rsp_valid;
    end
    chk({nm, ".latency"}, lat, v.lat);
    chk({nm, ".rdata"}, bus.o_read_data, v.rd);
    chk({nm, ".n_access"}, log_n - start, v.n);
    for (int j = 0; j < v.n && j < 4; j++) begin
      chk({nm, ".addr"}, {21'd0, log_addr[start+j]}, {21'd0, v.ea[j]});
      chk({nm, ".we"}, {31'd0, log_we[start+j]}, {31'd0, v.we});
      if (v.we) chk({nm, ".wbyte"}, {24'd0, log_d[start+j]}, {24'd0, v.ed[j]});
    end
    @(posedge clk);
    @(negedge clk);
    chk({nm, ".rsp_done"}, {31'd0, bus.o_rsp_valid}, 32'd0);
    chk({nm, ".ready_again"}, {31'd0, bus.o_req_ready}, 32'd1);
  endtask

  vec_t vecs [7];

  initial begin
    int start;
    bus.i_req_valid = 1'b0; bus.i_addr = '0; bus.i_write_enable = 1'b0;
    bus.i_write_data = '0; bus.i_mask = '0; bus.i_rsp_ready = 1'b1;

    vecs[0] = mkv(1'b0, 32'd0,     32'h0,        32'hffff_ffff, 32'hdead_beef, 6, 4,
                  {11'd3, 11'd2, 11'd1, 11'd0}, 32'h0);
    vecs[1] = mkv(1'b0, 32'd18,    32'h0,        32'hffff_0000, 32'hcafe_0000, 4, 2,
                  {11'd0, 11'd0, 11'd19, 11'd18}, 32'h0);
    vecs[2] = mkv(1'b1, 32'd8,     32'hb0ba_0000, 32'hffff_0000, 32'h0,        3, 2,
                  {11'd0, 11'd0, 11'd11, 11'd10}, 32'h0000_b0ba);
    vecs[3] = mkv(1'b1, 32'd4,     32'h1122_3344, 32'hff00_00ff, 32'h0,        3, 2,
                  {11'd0, 11'd0, 11'd7, 11'd4}, 32'h0000_1144);
    vecs[4] = mkv(1'b0, 32'd8,     32'h0,        32'hffff_ffff, 32'hb0ba_b0ba, 6, 4,
                  {11'd11, 11'd10, 11'd9, 11'd8}, 32'h0);
    vecs[5] = mkv(1'b0, 32'h812,   32'h0,        32'hffff_0000, 32'hcafe_0000, 4, 2,
                  {11'd0, 11'd0, 11'd19, 11'd18}, 32'h0);
    vecs[6] = mkv(1'b0, 32'd5,     32'h0,        32'h0000_ff00, 32'h0000_0200, 3, 1,
                  {11'd0, 11'd0, 11'd0, 11'd5}, 32'h0);

    // Reset state.
    #2;
    chk("rst.sram_en", {31'd0, sram_en}, 32'd0);
    chk("rst.sram_we", {31'd0, sram_we}, 32'd0);
    chk("rst.sram_addr", {21'd0, sram_addr}, 32'd0);
    chk("rst.rsp_valid", {31'd0, bus.o_rsp_valid}, 32'd0);
    chk("rst.read_data", bus.o_read_data, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1 chk("rst.req_ready", {31'd0, bus.o_req_ready}, 32'd1);

    poke(0, 8'hef);  poke(1, 8'hbe);  poke(2, 8'had);  poke(3, 8'hde);
    poke(16, 8'hba); poke(17, 8'hb0); poke(18, 8'hfe); poke(19, 8'hca);
    poke(8, 8'hba);  poke(9, 8'hb0);  poke(10, 8'hfe); poke(11, 8'hca);
    poke(4, 8'h01);  poke(5, 8'h02);  poke(6, 8'h03);  poke(7, 8'h04);

    for (int i = 0; i < 7; i++) do_req(vecs[i], $sformatf("vec%0d", i));

    chk("mem8",  {24'd0, mem[8]},  32'hba);
    chk("mem9",  {24'd0, mem[9]},  32'hb0);
    chk("mem10", {24'd0, mem[10]}, 32'hba);
    chk("mem11", {24'd0, mem[11]}, 32'hb0);
    chk("mem4",  {24'd0, mem[4]},  32'h44);
    chk("mem5",  {24'd0, mem[5]},  32'h02);
    chk("mem6",  {24'd0, mem[6]},  32'h03);
    chk("mem7",  {24'd0, mem[7]},  32'h11);

    // Zero mask with response back-pressure.
    @(negedge clk);
    start = log_n;
    bus.i_rsp_ready = 1'b0; bus.i_req_valid = 1'b1; bus.i_addr = 32'h40;
    bus.i_write_enable = 1'b0; bus.i_mask = 32'h0;
    @(posedge clk);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) bus.i_req_valid = 1'b0;
      chk("zm.rsp_valid", {31'd0, bus.o_rsp_valid}, 32'd1);
      chk("zm.req_ready", {31'd0, bus.o_req_ready}, 32'd0);
      chk("zm.read_data", bus.o_read_data, 32'd0);
    end
    bus.i_rsp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("zm.rsp_done", {31'd0, bus.o_rsp_valid}, 32'd0);
    chk("zm.ready_again", {31'd0, bus.o_req_ready}, 32'd1);
    chk("zm.no_sram", log_n - start, 32'd0);

    // Reset in the middle of a full-mask store.
    @(negedge clk);
    bus.i_req_valid = 1'b1; bus.i_addr = 32'd0; bus.i_write_enable = 1'b1;
    bus.i_write_data = 32'haabb_ccdd; bus.i_mask = 32'hffff_ffff;
    @(posedge clk);
    @(negedge clk) bus.i_req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("mid.sram_en", {31'd0, sram_en}, 32'd0);
    chk("mid.sram_we", {31'd0, sram_we}, 32'd0);
    chk("mid.rsp_valid", {31'd0, bus.o_rsp_valid}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1 chk("mid.req_ready", {31'd0, bus.o_req_ready}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("mid.no_rsp", {31'd0, bus.o_rsp_valid}, 32'd0);
    end
    chk("mid.mem0", {24'd0, mem[0]}, 32'hdd);
    chk("mid.mem1", {24'd0, mem[1]}, 32'hcc);
    chk("mid.mem2", {24'd0, mem[2]}, 32'had);
    chk("mid.mem3", {24'd0, mem[3]}, 32'hde);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/dmem_byte_bridge.md
Name: dmem_byte_bridge

Overview:
Responder end of the core's data-memory interface: accepts word-wide, byte-masked load/store requests and serves them from a byte-wide synchronous SRAM. Requests are serialised one byte lane per cycle, and read bytes are reassembled into a lane-positioned, masked 32-bit word. Sits between the load/store path of `cpu` and an external 8-bit SRAM macro, replacing the single-cycle `dmem` array. A valid/ready handshake is used on both request and response.

Parameters:
ADDR_W, 11, SRAM byte-address width; `o_sram_addr` width.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous reset, active-high
- i_req_valid  in  1  request present
- o_req_ready  out  1  bridge can accept a request
- i_addr  in  32  byte address; bits [1:0] ignored, bits [ADDR_W-1:2] used
- i_write_enable  in  1  1 = store, 0 = load
- i_write_data  in  32  store data, already lane-positioned
- i_mask  in  32  byte-granular bit mask; lane k is enabled iff i_mask[8k] = 1
- o_rsp_valid  out  1  response available
- i_rsp_ready  in  1  consumer takes the response
- o_read_data  out  32  load result; unselected lanes are 0; 0 for stores
- o_sram_en  out  1  SRAM access strobe
- o_sram_we  out  1  SRAM write strobe
- o_sram_addr  out  ADDR_W  SRAM byte address
- o_sram_wdata  out  8  SRAM write byte
- i_sram_rdata  in  8  SRAM read byte, valid the cycle after the en/!we access

Behaviour:
- Reset (async, i_rst = 1):
  - state = IDLE.
  - o_req_ready = 1 once reset is released.
  - All other outputs are 0; captured request registers are cleared.
- States: IDLE, ACCESS, DRAIN, RESP.
- o_req_ready = (state == IDLE); no other state accepts a request.
- Acceptance: handshake (i_req_valid & o_req_ready) at edge E0.
  - Latch addr, we, wdata and the 4-bit lane enable vector.
  - Clear the read-assembly register.
  - Next state:
    - 0 lanes enabled -> RESP; no SRAM activity.
    - otherwise -> ACCESS.
- ACCESS: one enabled lane per cycle, ascending lane order (0..3); disabled lanes are skipped, costing no cycle.
  - o_sram_en = 1.
  - o_sram_we = latched we.
  - o_sram_addr = {addr[ADDR_W-1:2], lane[1:0]}.
  - o_sram_wdata = wdata[8*lane+7 : 8*lane].
  - Load: i_sram_rdata is captured into assembly byte `lane` one cycle after that lane's issue.
  - After the last enabled lane is issued:
    - store -> RESP.
    - load -> DRAIN.
- DRAIN: one cycle, o_sram_en = 0; captures the final read byte, then -> RESP.
- RESP:
  - o_rsp_valid = 1.
  - o_read_data = assembly register (load) or 0 (store).
  - Held stable until i_rsp_ready = 1 at a clock edge, then -> IDLE.
- Latency (N = enabled lanes, i_rsp_ready held 1):
  - Store: o_rsp_valid is high in cycle N+1 after E0.
  - Load: o_rsp_valid is high in cycle N+2 after E0.
  - Zero-mask request: o_rsp_valid is high in cycle 1 after E0.
  - Next request is accepted earliest in the cycle after the response handshake; no request/response overlap.
- o_sram_en = 0 in IDLE, DRAIN and RESP; o_sram_we is never 1 unless o_sram_en = 1.
- Inputs i_addr, i_write_data and i_mask are sampled only at acceptance; later changes have no effect.
- Address wrap: bits above ADDR_W-1 are discarded; no error reporting.
- Reset mid-operation:
  - Immediate return to IDLE; o_sram_en and o_sram_we drop asynchronously.
  - The partial store stays partial (lanes already written stay written).
  - No response is issued for the aborted request.

Test Plan:
1. Load, full mask.
   - Stimulus: SRAM bytes 0..3 = ef,be,ad,de; request addr=0, we=0, mask=ffffffff.
   - Required: 4 consecutive SRAM reads at addresses 0,1,2,3; o_rsp_valid in cycle 6 after E0; o_read_data = deadbeef.
2. Halfword load, upper lanes.
   - Stimulus: SRAM bytes 16..19 = ba,b0,fe,ca; addr=18, mask=ffff0000.
   - Required: reads at 18,19 only; o_rsp_valid in cycle 4 after E0; o_read_data = cafe0000.
3. Halfword store.
   - Stimulus: SRAM bytes 8..11 = ba,b0,fe,ca; addr=8, we=1, wdata=b0ba0000, mask=ffff0000.
   - Required: writes ba@10, b0@11; bytes 8..9 untouched; o_rsp_valid in cycle 3 after E0; o_read_data = 0.
4. Zero mask and back-pressure.
   - Stimulus: mask=0 with i_rsp_ready=0 for 5 cycles.
   - Required: no o_sram_en; o_rsp_valid high from cycle 1 and held stable; o_req_ready=0 until the response handshake, then 1 the next cycle.
5. Byte store, sparse mask.
   - Stimulus: addr=4, wdata=11223344, mask=ff0000ff.
   - Required: exactly 2 write cycles, 44@4 then 11@7; bytes 5,6 unchanged.
6. Reset mid-store.
   - Stimulus: full-mask store of aabbccdd to addr 0; assert i_rst after lane 1 is written.
   - Required: bytes 0,1 = dd,cc; bytes 2,3 unchanged; o_sram_en=0 immediately; no o_rsp_valid; o_req_ready=1 after release.
